mipi_hs_lane_aligner: RTL

MIPI_HS_LANE_ALIGNER -- requirements
Module: mipi_hs_lane_aligner

---
 rtl/mipi_dsi_pkg.sv | 12 +
 rtl/mipi_lane_byte_align.sv | 78 +++++++
 rtl/mipi_hs_lane_aligner.sv | 110 +++++++++++
 3 files changed

// File: rtl/mipi_dsi_pkg.sv
// Shared definitions for the MIPI D-PHY HS receive path: lane count,
// default sync pattern and the lane aligner state encoding.
package mipi_dsi_pkg;
  localparam int NUM_LANES = 4;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hB8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HUNT  = 2'd1,
    ST_BURST = 2'd2
  } hs_state_e;
endpackage

// File: rtl/mipi_lane_byte_align.sv
// One data lane: 16-bit window, sync offset search, lock capture and the
// deskew shift buffer feeding the registered output byte.
module mipi_lane_byte_align import mipi_dsi_pkg::*; #(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int MAX_SKEW = 3,
  parameter int CW = 5,
  parameter int DW = 2
) (
  input  logic          div_clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          hunt,
  input  logic [CW-1:0] cyc,
  input  logic [7:0]    ddr_bits,
  input  logic [DW-1:0] dly,
  input  logic          load,
  output logic          lock_now,
  output logic [CW-1:0] lock_cyc,
  output logic [7:0]    buf_byte
);
  logic [7:0]  prev_q;
  logic [15:0] win;
  logic        hit, found, locked_q;
  logic [2:0]  hit_ofs, ofs_q;
  logic [CW-1:0] cyc_q;
  logic [7:0]  aligned, tap;
  logic [MAX_SKEW-1:0][7:0] sr_q;

  assign win = {ddr_bits, prev_q};

  // Descending scan so the lowest matching offset is the one left standing.
  always_comb begin
    hit = 1'b0;
    hit_ofs = '0;
    for (int k = 7; k >= 0; k--)
      if (win[k +: 8] == SYNC_BYTE) begin
        hit = 1'b1;
        hit_ofs = 3'(k);
      end
  end

  assign found    = hunt && !locked_q && hit;
  assign lock_now = locked_q || found;
  assign lock_cyc = locked_q ? cyc_q : cyc;
  assign aligned  = win[ofs_q +: 8];

  // The live aligned byte is tap 0; sr_q supplies taps 1..MAX_SKEW.
  always_comb begin
    tap = aligned;
    for (int j = 1; j <= MAX_SKEW; j++)
      if (int'(dly) == j) tap = sr_q[j-1];
  end

  always_ff @(posedge div_clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q   <= '0;
      locked_q <= 1'b0;
      ofs_q    <= '0;
      cyc_q    <= '0;
      sr_q     <= '0;
      buf_byte <= '0;
    end else begin
      prev_q <= ddr_bits;
      if (clr) begin
        locked_q <= 1'b0;
        ofs_q    <= '0;
        cyc_q    <= '0;
      end else if (found) begin
        locked_q <= 1'b1;
        ofs_q    <= hit_ofs;
        cyc_q    <= cyc;
      end
      sr_q[0] <= aligned;
      for (int j = 1; j < MAX_SKEW; j++) sr_q[j] <= sr_q[j-1];
      buf_byte <= load ? tap : 8'h00;
    end
  end
endmodule

// File: rtl/mipi_hs_lane_aligner.sv
// Four-lane HS byte aligner/deskewer: per-lane align units plus the
// IDLE/HUNT/BURST controller that gates the payload onto the outputs.
module mipi_hs_lane_aligner import mipi_dsi_pkg::*; #(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int HUNT_TIMEOUT = 16,
  parameter int MAX_SKEW = 3
) (
  input  logic       div_clk,
  input  logic       rst_n,
  input  logic       lane_lp_idle,
  input  logic [7:0] ddr_bits_lane0,
  input  logic [7:0] ddr_bits_lane1,
  input  logic [7:0] ddr_bits_lane2,
  input  logic [7:0] ddr_bits_lane3,
  output logic [7:0] ddr_bits_lane0_buf,
  output logic [7:0] ddr_bits_lane1_buf,
  output logic [7:0] ddr_bits_lane2_buf,
  output logic [7:0] ddr_bits_lane3_buf,
  output logic       hs_burst_flag,
  output logic       sync_err
);
  localparam int CW = $clog2(HUNT_TIMEOUT + 1);
  localparam int DW = (MAX_SKEW > 1) ? $clog2(MAX_SKEW + 1) : 1;
  localparam logic [CW-1:0] TO_LAST  = CW'(HUNT_TIMEOUT - 1);
  localparam logic [CW-1:0] SKEW_LIM = CW'(MAX_SKEW);

  hs_state_e state_q, state_d;
  logic [CW-1:0] hunt_cnt_q, cyc_max, cyc_min;
  logic armed_q, flag_q, err_q, err_d, spread_bad, load;
  logic [NUM_LANES-1:0] lock_now;
  logic [NUM_LANES-1:0][CW-1:0] lock_cyc;
  logic [NUM_LANES-1:0][DW-1:0] dly;
  logic [NUM_LANES-1:0][7:0] ddr, buf_bytes;

  assign ddr = {ddr_bits_lane3, ddr_bits_lane2, ddr_bits_lane1, ddr_bits_lane0};
  assign ddr_bits_lane0_buf = buf_bytes[0];
  assign ddr_bits_lane1_buf = buf_bytes[1];
  assign ddr_bits_lane2_buf = buf_bytes[2];
  assign ddr_bits_lane3_buf = buf_bytes[3];
  assign hs_burst_flag = flag_q;
  assign sync_err      = err_q;
  assign load = (state_q == ST_BURST) && !lane_lp_idle;

  mipi_lane_byte_align #(
    .SYNC_BYTE(SYNC_BYTE), .MAX_SKEW(MAX_SKEW), .CW(CW), .DW(DW)
  ) u_lane [NUM_LANES-1:0] (
    .div_clk  (div_clk),
    .rst_n    (rst_n),
    .clr      (state_q == ST_IDLE),
    .hunt     (state_q == ST_HUNT),
    .cyc      (hunt_cnt_q),
    .ddr_bits (ddr),
    .dly      (dly),
    .load     (load),
    .lock_now (lock_now),
    .lock_cyc (lock_cyc),
    .buf_byte (buf_bytes)
  );

  // Lock-cycle spread over the lanes locked so far; in BURST these are the
  // held values, so the per-lane delays stay constant for the whole burst.
  always_comb begin
    cyc_max = '0;
    cyc_min = '1;
    for (int i = 0; i < NUM_LANES; i++)
      if (lock_now[i]) begin
        if (lock_cyc[i] > cyc_max) cyc_max = lock_cyc[i];
        if (lock_cyc[i] < cyc_min) cyc_min = lock_cyc[i];
      end
    spread_bad = (|lock_now) && ((cyc_max - cyc_min) > SKEW_LIM);
    for (int i = 0; i < NUM_LANES; i++) dly[i] = DW'(cyc_max - lock_cyc[i]);
  end

  // A new hunt needs an LP-11 sample since the last hunt (or reset), so a
  // failed hunt never retriggers while the lanes stay in HS.
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE:  if (armed_q && !lane_lp_idle) state_d = ST_HUNT;
      ST_HUNT: begin
        if (lane_lp_idle) state_d = ST_IDLE;
        else if (&lock_now && !spread_bad) state_d = ST_BURST;
        else if (spread_bad || hunt_cnt_q == TO_LAST) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      ST_BURST: if (lane_lp_idle) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge div_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      hunt_cnt_q <= '0;
      armed_q    <= 1'b0;
      flag_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hunt_cnt_q <= (state_q == ST_HUNT) ? hunt_cnt_q + 1'b1 : '0;
      if (lane_lp_idle) armed_q <= 1'b1;
      else if (state_q != ST_IDLE) armed_q <= 1'b0;
      flag_q <= load;
      err_q  <= err_d;
    end
  end
endmodule
